// File: rtl/rename_pkg.sv
// Shared renamer types: retire-queue entry layout and the retire bus.
// The retire bus is consumed unchanged by the renamer's free-list side.
package rename_pkg;

    localparam int PREG_W = 4;
    localparam int ARCH_W = 5;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [PREG_W-1:0] oldpreg;
    } rq_entry_t;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic              valid;
    } retire_t;

endpackage

// File: rtl/retire_queue.sv
// In-order commit tracker: entries complete out of order, retire at head.
// Each retire returns the displaced physical register to the renamer.
module retire_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 4,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [PREG_W-1:0] alloc_oldpreg,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic [PREG_W:0]   retireout,
    output logic              empty,
    output logic              full
);

    import rename_pkg::*;

    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    rq_entry_t ent_q [DEPTH];
    rq_entry_t ent_d [DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    retire_t          ret_q, ret_d;

    logic alloc_fire;
    logic commit_fire;

    // Occupancy flags come only from the registered count.
    always_comb begin
        alloc_ready = (count_q < DEPTH_C);
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        alloc_tag   = tail_q;
        retireout   = ret_q;
    end

    // Handshake decisions use pre-edge state only.
    always_comb begin
        alloc_fire  = alloc_valid && alloc_ready;
        commit_fire = ent_q[head_q].busy && ent_q[head_q].done;
    end

    // Entry array update: complete, then commit clear, then alloc write.
    always_comb begin
        ent_d = ent_q;
        if (complete_valid && ent_q[complete_tag].busy) begin
            ent_d[complete_tag].done = 1'b1;
        end
        if (commit_fire) begin
            ent_d[head_q].busy = 1'b0;
            ent_d[head_q].done = 1'b0;
        end
        if (alloc_fire) begin
            ent_d[tail_q].busy    = 1'b1;
            ent_d[tail_q].done    = 1'b0;
            ent_d[tail_q].oldpreg = alloc_oldpreg;
        end
    end

    // Pointer, count and retire-bus next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ret_d   = '0;
        if (commit_fire) begin
            head_d     = head_q + TAG_W'(1);
            ret_d.preg  = ent_q[head_q].oldpreg;
            ret_d.valid = 1'b1;
        end
        if (alloc_fire) begin
            tail_d = tail_q + TAG_W'(1);
        end
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ret_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ret_q   <= ret_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_retire_queue.sv
// Self-checking bench for retire_queue against a queue-based model.
// Directed scenarios followed by a randomized run.
module tb_retire_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_valid = 1'b0;
    logic [3:0] alloc_oldpreg = '0;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic       complete_valid = 1'b0;
    logic [2:0] complete_tag = '0;
    logic [4:0] retireout;
    logic       empty;
    logic       full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] tag;
        logic [3:0] preg;
        bit         done;
    } mq_t;

    mq_t        mq[$];
    logic [2:0] m_tail;
    logic [4:0] exp_ret;

    always #5 clk = ~clk;

    retire_queue #(.DEPTH(8), .PREG_W(4), .TAG_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_oldpreg  (alloc_oldpreg),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .complete_valid (complete_valid),
        .complete_tag   (complete_tag),
        .retireout      (retireout),
        .empty          (empty),
        .full           (full)
    );

    task automatic model_reset();
        mq.delete();
        m_tail  = '0;
        exp_ret = '0;
    endtask

    task automatic drive(input bit av, input logic [3:0] p,
                         input bit cv, input logic [2:0] t);
        alloc_valid    = av;
        alloc_oldpreg  = p;
        complete_valid = cv;
        complete_tag   = t;
    endtask

    // Advance one clock, updating the model from the applied inputs.
    task automatic tick();
        bit commit;
        bit rdy;
        commit = (mq.size() > 0) && mq[0].done;
        rdy    = (mq.size() < DEPTH);
        if (complete_valid) begin
            foreach (mq[i]) if (mq[i].tag == complete_tag) mq[i].done = 1'b1;
        end
        if (commit) begin
            exp_ret = {mq[0].preg, 1'b1};
            void'(mq.pop_front());
        end else begin
            exp_ret = '0;
        end
        if (alloc_valid && rdy) begin
            mq.push_back('{tag: m_tail, preg: alloc_oldpreg, done: 1'b0});
            m_tail = m_tail + 3'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (retireout !== 5'h00 || empty !== 1'b1 || full !== 1'b0 ||
            alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold ret=%h empty=%b full=%b rdy=%b tag=%0d required 00 1 0 1 0",
                     retireout, empty, full, alloc_ready, alloc_tag);
        end
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (retireout !== 5'h00 || empty !== 1'b1 ||
                alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d ret=%h empty=%b rdy=%b tag=%0d required 00 1 1 0",
                         i, retireout, empty, alloc_ready, alloc_tag);
            end
        end
    endtask

    task automatic test_in_order();
        logic [4:0] got[$];
        int         cyc[$];
        drive(1, 4'd5, 0, 0); tick();
        drive(1, 4'd6, 0, 0); tick();
        drive(1, 4'd7, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(0, 0, 1, 3'(i));
            else       drive(0, 0, 0, 0);
            tick();
            checks++;
            if (retireout !== exp_ret) begin
                errors++;
                $display("FAIL in_order_ret cyc=%0d got=%h required=%h", i, retireout, exp_ret);
            end
            if (retireout[0] === 1'b1) begin
                got.push_back(retireout);
                cyc.push_back(i);
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL in_order_count got=%0d required=3", got.size());
        end else if (got[0] !== 5'h0B || got[1] !== 5'h0D || got[2] !== 5'h0F ||
                     cyc[1] != cyc[0] + 1 || cyc[2] != cyc[1] + 1) begin
            errors++;
            $display("FAIL in_order_seq got=%h %h %h at %0d %0d %0d required 0b 0d 0f consecutive",
                     got[0], got[1], got[2], cyc[0], cyc[1], cyc[2]);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL in_order_empty got=%b required=1", empty);
        end
    endtask

    task automatic test_out_of_order();
        logic [2:0] base;
        logic [3:0] p[3];
        logic [4:0] got[$];
        int         cyc[$];
        base = m_tail;
        for (int i = 0; i < 3; i++) begin
            p[i] = 4'($urandom_range(0, 15));
            drive(1, p[i], 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, base + 3'(2 - i));
            tick();
            checks++;
            if (retireout !== 5'h00) begin
                errors++;
                $display("FAIL ooo_early cyc=%0d got=%h required=00", i, retireout);
            end
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (retireout !== exp_ret) begin
                errors++;
                $display("FAIL ooo_ret cyc=%0d got=%h required=%h", i, retireout, exp_ret);
            end
            if (retireout[0] === 1'b1) begin
                got.push_back(retireout);
                cyc.push_back(i);
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL ooo_count got=%0d required=3", got.size());
        end else if (got[0] !== {p[0], 1'b1} || got[1] !== {p[1], 1'b1} ||
                     got[2] !== {p[2], 1'b1} || cyc[0] != 0 ||
                     cyc[1] != 1 || cyc[2] != 2) begin
            errors++;
            $display("FAIL ooo_order got=%h %h %h required=%h %h %h",
                     got[0], got[1], got[2], {p[0], 1'b1}, {p[1], 1'b1}, {p[2], 1'b1});
        end
    endtask

    task automatic test_full();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'(i + 1), 0, 0);
            tick();
        end
        checks++;
        if (full !== 1'b1 || alloc_ready !== 1'b0 || alloc_tag !== 3'd0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags full=%b rdy=%b tag=%0d empty=%b required 1 0 0 0",
                     full, alloc_ready, alloc_tag, empty);
        end
        drive(1, 4'hF, 0, 0);
        tick();
        checks++;
        if (full !== 1'b1 || alloc_tag !== 3'd0 || retireout !== 5'h00) begin
            errors++;
            $display("FAIL full_drop full=%b tag=%0d ret=%h required 1 0 00",
                     full, alloc_tag, retireout);
        end
        drive(0, 0, 1, 3'd0);
        tick();
        checks++;
        if (retireout !== 5'h00 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_complete ret=%h full=%b required 00 1", retireout, full);
        end
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (retireout !== 5'h03 || retireout !== exp_ret) begin
            errors++;
            $display("FAIL full_retire got=%h required=03", retireout);
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_wrap rdy=%b tag=%0d full=%b required 1 0 0",
                     alloc_ready, alloc_tag, full);
        end
        for (int i = 1; i < 11; i++) begin
            if (i < 8) drive(0, 0, 1, 3'(i));
            else       drive(0, 0, 0, 0);
            tick();
            checks++;
            if (retireout !== exp_ret || retireout === 5'h1F) begin
                errors++;
                $display("FAIL full_drain cyc=%0d got=%h required=%h", i, retireout, exp_ret);
            end
        end
        checks++;
        if (empty !== 1'b1 || alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL full_empty empty=%b tag=%0d required 1 0", empty, alloc_tag);
        end
    endtask

    task automatic test_stray_complete();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 3'd5);
            tick();
            checks++;
            if (retireout !== 5'h00 || empty !== 1'b1 || alloc_tag !== m_tail) begin
                errors++;
                $display("FAIL stray ret=%h empty=%b tag=%0d required 00 1 %0d",
                         retireout, empty, alloc_tag, m_tail);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_midflight();
        logic [2:0] base;
        int         nret;
        base = m_tail;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(8 + i), 0, 0);
            tick();
        end
        drive(0, 0, 1, base);
        tick();
        drive(0, 0, 1, base + 3'd1);
        tick();
        checks++;
        if (retireout !== exp_ret || retireout[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got=%h required=%h", retireout, exp_ret);
        end
        drive(0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (retireout !== 5'h00 || empty !== 1'b1 || full !== 1'b0 ||
            alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL midrst_async ret=%h empty=%b full=%b rdy=%b tag=%0d required 00 1 0 1 0",
                     retireout, empty, full, alloc_ready, alloc_tag);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        drive(1, 4'd9, 0, 0);
        checks++;
        if (alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL midrst_tag got=%0d required=0", alloc_tag);
        end
        tick();
        nret = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(0, 0, 1, 3'(i));
            else       drive(0, 0, 0, 0);
            tick();
            checks++;
            if (retireout !== exp_ret) begin
                errors++;
                $display("FAIL midrst_stale cyc=%0d got=%h required=%h", i, retireout, exp_ret);
            end
            if (retireout[0] === 1'b1) nret++;
        end
        checks++;
        if (nret != 1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_count retires=%0d empty=%b required 1 1", nret, empty);
        end
    endtask

    task automatic test_random();
        logic [2:0] t;
        for (int c = 0; c < 400; c++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                t = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                t = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, t);
            tick();
            checks++;
            if (retireout !== exp_ret) begin
                errors++;
                $display("FAIL rand_ret cyc=%0d got=%h required=%h", c, retireout, exp_ret);
            end
            checks++;
            if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                alloc_ready !== (mq.size() < DEPTH) || alloc_tag !== m_tail) begin
                errors++;
                $display("FAIL rand_flags cyc=%0d empty=%b full=%b rdy=%b tag=%0d required size=%0d tag=%0d",
                         c, empty, full, alloc_ready, alloc_tag, mq.size(), m_tail);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_full();
        test_stray_complete();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
